// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, latency defaults and shared types for the mult/div scheduler
package muldiv_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MADD  = 3'd4;
  localparam logic [2:0] MD_MSUB  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef logic [63:0] md_res_t;
  typedef enum logic {IDLE, BUSY} md_state_t;
endpackage

// File: rtl/muldiv_calc.sv
// muldiv_calc: combinational 64-bit {HI,LO} result for mult/div/madd/msub
//   op  : op encoding (MD_*)      a, b : rs/rt operands
//   acc : current {HI,LO}         res  : {HI,LO} result
module muldiv_calc
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_res_t     acc,
  output md_res_t     res
);
  logic sdiv, na, nb;
  logic [31:0] ma, mb, dv, q, r;
  md_res_t sprod, uprod, divres;
  // signed divide runs on magnitudes, signs are restored afterwards;
  // 0x80000000/-1 falls out naturally as quotient 0x80000000, remainder 0
  assign sdiv   = op == MD_DIV;
  assign na     = sdiv & a[31];
  assign nb     = sdiv & b[31];
  assign ma     = na ? -a : a;
  assign mb     = nb ? -b : b;
  assign dv     = b == 32'd0 ? 32'd1 : mb;
  assign q      = ma / dv;
  assign r      = ma % dv;
  assign sprod  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod  = {32'd0, a} * {32'd0, b};
  assign divres = b == 32'd0 ? {a, 32'hFFFF_FFFF} : {na ? -r : r, (na ^ nb) ? -q : q};
  assign res    = op == MD_MULT  ? sprod :
                  op == MD_MULTU ? uprod :
                  op == MD_MADD  ? acc + sprod :
                  op == MD_MSUB  ? acc - sprod : divres;
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle mult/div scheduler owning HI/LO, with stall toward the hazard unit
//   clk, rst_n      : clock, async active-low reset
//   EX_start/op/A/B : mult/div/mthi/mtlo issued from EX
//   EX_cancel       : flush, aborts the in-flight op or a same-cycle start
//   ID_hilo_use     : ID holds an instruction touching HI/LO
//   HI, LO          : architectural registers
//   md_busy         : op in flight      md_stall : stall request
//   MULDIV_MADD_EN  : when defined, ops 4/5 (MADD/MSUB) accumulate; otherwise they are no-ops
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_start,
  input  logic [2:0]  EX_op,
  input  logic [31:0] EX_A,
  input  logic [31:0] EX_B,
  input  logic        EX_cancel,
  input  logic        ID_hilo_use,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_busy,
  output logic        md_stall
);
  md_state_t state, nxt;
  logic [3:0] cnt;
  md_res_t pend, res;
  logic take, is_div, is_long, go, mt, last;
  muldiv_calc u_calc (.op(EX_op), .a(EX_A), .b(EX_B), .acc({HI, LO}), .res(res));
  assign take   = state == IDLE & EX_start & ~EX_cancel;
  assign is_div = EX_op == MD_DIV | EX_op == MD_DIVU;
`ifdef MULDIV_MADD_EN
  assign is_long = EX_op <= MD_MSUB;
`else
  assign is_long = EX_op <= MD_DIVU;
`endif
  assign go   = take & is_long;
  assign mt   = take & (EX_op == MD_MTHI | EX_op == MD_MTLO);
  assign last = state == BUSY & cnt == 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (go ? BUSY : IDLE) : ((EX_cancel | last) ? IDLE : BUSY);
  always_comb begin
    md_busy  = state == BUSY;
    md_stall = ID_hilo_use & (md_busy | EX_start);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= 4'd0;
      pend <= '0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else begin
      if (go) begin
        cnt  <= is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
        pend <= res;
      end else if (state == BUSY)
        cnt <= EX_cancel ? 4'd0 : cnt - 4'd1;
      // cancel on the final edge beats the commit
      if (last & ~EX_cancel) {HI, LO} <= pend;
      if (mt & EX_op == MD_MTHI) HI <= EX_A;
      if (mt & EX_op == MD_MTLO) LO <= EX_A;
    end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed self-checking bench for muldiv_sched
module tb_muldiv_sched;
  logic clk = 0, rst_n, EX_start, EX_cancel, ID_hilo_use, md_busy, md_stall;
  logic [2:0] EX_op;
  logic [31:0] EX_A, EX_B, HI, LO;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  muldiv_sched dut (
    .clk(clk), .rst_n(rst_n), .EX_start(EX_start), .EX_op(EX_op), .EX_A(EX_A), .EX_B(EX_B),
    .EX_cancel(EX_cancel), .ID_hilo_use(ID_hilo_use), .HI(HI), .LO(LO),
    .md_busy(md_busy), .md_stall(md_stall)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    EX_start = 1; EX_op = op; EX_A = a; EX_B = b;
    tick;
    EX_start = 0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (md_busy && n < 40) begin
      tick;
      n++;
    end
    check(tag, {31'd0, md_busy}, 32'd0);
  endtask
  initial begin
    rst_n = 0; EX_start = 0; EX_op = 0; EX_A = 0; EX_B = 0; EX_cancel = 0; ID_hilo_use = 0;
    #12;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", {31'd0, md_busy}, 0);
    check("rst_stall", {31'd0, md_stall}, 0);
    tick;
    rst_n = 1;
    tick;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 5; i++) begin
      check("mult_busy", {31'd0, md_busy}, 1);
      if (i == 4) check("mult_hi_early", HI, 0);
      tick;
    end
    check("mult_busy_end", {31'd0, md_busy}, 0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFEB);
    ID_hilo_use = 1;
    EX_start = 1; EX_op = 3'd3; EX_A = 100; EX_B = 7;
    #1;
    check("divu_stall_start", {31'd0, md_stall}, 1);
    tick;
    EX_start = 0;
    for (int i = 0; i < 10; i++) begin
      check("divu_stall_busy", {31'd0, md_stall}, 1);
      tick;
    end
    check("divu_stall_end", {31'd0, md_stall}, 0);
    check("divu_lo", LO, 14);
    check("divu_hi", HI, 2);
    ID_hilo_use = 0;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg_to");
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_negb_to");
    check("div_negb_lo", LO, 32'hFFFF_FFFD);
    check("div_negb_hi", HI, 32'd1);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle("div0_to");
    check("div0_lo", LO, 32'hFFFF_FFFF);
    check("div0_hi", HI, 32'd5);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_to");
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("ovf_to");
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);
    issue(3'd6, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, md_busy}, 0);
    check("mthi_lo", LO, 32'h8000_0000);
    issue(3'd7, 32'd0, 32'd0);
    issue(3'd6, 32'd0, 32'd0);
    check("mtlo_lo", LO, 0);
    issue(3'd0, 32'd4, 32'd4);
    repeat (2) tick;
    EX_cancel = 1;
    tick;
    EX_cancel = 0;
    check("cancel_busy", {31'd0, md_busy}, 0);
    repeat (6) tick;
    check("cancel_hi", HI, 0);
    check("cancel_lo", LO, 0);
    EX_cancel = 1;
    issue(3'd0, 32'd4, 32'd4);
    EX_cancel = 0;
    check("start_cancel_busy", {31'd0, md_busy}, 0);
    issue(3'd0, 32'd2, 32'd3);
    tick;
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) tick;
    check("ignored_busy", {31'd0, md_busy}, 1);
    tick;
    check("ignored_done", {31'd0, md_busy}, 0);
    check("ignored_lo", LO, 6);
    check("ignored_hi", HI, 0);
    issue(3'd0, 32'd5, 32'd5);
    repeat (4) tick;
    EX_cancel = 1;
    tick;
    EX_cancel = 0;
    check("last_cancel_busy", {31'd0, md_busy}, 0);
    check("last_cancel_lo", LO, 6);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) tick;
    rst_n = 0;
    #1;
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    check("midrst_busy", {31'd0, md_busy}, 0);
    tick;
    rst_n = 1;
    repeat (12) tick;
    check("midrst_nocommit", LO, 0);
    issue(3'd7, 32'd10, 32'd0);
    issue(3'd4, 32'd3, 32'd4);
`ifdef MULDIV_MADD_EN
    check("madd_busy", {31'd0, md_busy}, 1);
    wait_idle("madd_to");
    check("madd_lo", LO, 22);
`else
    check("madd_off_busy", {31'd0, md_busy}, 0);
    check("madd_off_lo", LO, 10);
`endif
    check("madd_hi", HI, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
